// File: rtl/serv_mdu_pkg.sv
// Shared definitions for the MDU responder: data width, RV32M funct3
// encodings and the handshake FSM state type.
package serv_mdu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE,
    S_WAIT
  } mdu_state_e;

endpackage

// File: rtl/serv_mdu_iter.sv
// Iterative unsigned multiply / restoring divide datapath.
//  clk       in   clock
//  i_load    in   load operands (hi cleared; lo/opnd from i_a/i_b)
//  i_step    in   perform UNROLL iteration steps this cycle
//  i_is_div  in   1 = divide step, 0 = multiply step
//  i_a, i_b  in   operand magnitudes (A, B)
//  o_hi      out  product high word / remainder
//  o_lo      out  product low word / quotient
// Multiply: lo holds the multiplier and shifts out LSB-first while product
// bits shift in from the top; opnd is the multiplicand.
// Divide: lo holds the dividend and shifts out MSB-first into hi while
// quotient bits shift in at the bottom; opnd is the divisor.
module serv_mdu_iter
  import serv_mdu_pkg::*;
#(
  parameter int unsigned UNROLL = 1
) (
  input  logic            clk,
  input  logic            i_load,
  input  logic            i_step,
  input  logic            i_is_div,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);

  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic [XLEN:0]   tmp;

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    opnd_d = opnd_q;
    tmp    = '0;
    if (i_load) begin
      hi_d = '0;
      if (i_is_div) begin
        lo_d   = i_a;
        opnd_d = i_b;
      end else begin
        lo_d   = i_b;
        opnd_d = i_a;
      end
    end else if (i_step) begin
      for (int unsigned i = 0; i < UNROLL; i++) begin
        if (i_is_div) begin
          tmp  = {hi_d, lo_d[XLEN-1]};
          lo_d = {lo_d[XLEN-2:0], 1'b0};
          if (tmp >= {1'b0, opnd_q}) begin
            tmp     = tmp - {1'b0, opnd_q};
            lo_d[0] = 1'b1;
          end
          hi_d = tmp[XLEN-1:0];
        end else begin
          tmp  = {1'b0, hi_d} + (lo_d[0] ? {1'b0, opnd_q} : '0);
          lo_d = {tmp[0], lo_d[XLEN-1:1]};
          hi_d = tmp[XLEN:1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    hi_q   <= hi_d;
    lo_q   <= lo_d;
    opnd_q <= opnd_d;
  end

  assign o_hi = hi_q;
  assign o_lo = lo_q;

endmodule

// File: rtl/serv_mdu_responder.sv
// Responder for the core's extension/MDU interface (RV32M).
//  clk           in   clock
//  i_rst         in   synchronous active-high reset
//  i_mdu_valid   in   op request, held until o_ext_ready is seen
//  i_ext_rs1     in   operand A
//  i_ext_rs2     in   operand B
//  i_ext_funct3  in   RV32M funct3
//  o_ext_rd      out  result, zero outside the ready pulse
//  o_ext_ready   out  one-cycle completion pulse
// Latency from valid accepted in IDLE to ready is 32/UNROLL + 1 cycles.
module serv_mdu_responder
  import serv_mdu_pkg::*;
#(
  parameter int unsigned UNROLL         = 1,
  parameter              RESET_STRATEGY = "MINI"
) (
  input  logic            clk,
  input  logic            i_rst,
  input  logic            i_mdu_valid,
  input  logic [XLEN-1:0] i_ext_rs1,
  input  logic [XLEN-1:0] i_ext_rs2,
  input  logic [2:0]      i_ext_funct3,
  output logic [XLEN-1:0] o_ext_rd,
  output logic            o_ext_ready
);

  localparam int unsigned N        = XLEN / UNROLL;
  localparam logic [5:0]  LAST     = 6'(N - 1);
  localparam bit          RST_OUTS = (RESET_STRATEGY != "NONE");

  mdu_state_e      state_q, state_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [2:0]      f3_q, f3_d;
  logic            sa_q, sa_d, sb_q, sb_d, bz_q, bz_d;
  logic            ready_q, ready_d;
  logic [XLEN-1:0] rd_q, rd_d;

  logic            load, is_div, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag, hi, lo, q_fix, r_fix, result;
  logic [2*XLEN-1:0] prod, prod_fix;

  // Operand conditioning: magnitudes only for operands signed under funct3.
  always_comb begin
    if (i_ext_funct3[2]) begin
      a_neg = i_ext_rs1[XLEN-1] && !i_ext_funct3[0];
      b_neg = i_ext_rs2[XLEN-1] && !i_ext_funct3[0];
    end else begin
      a_neg = i_ext_rs1[XLEN-1] &&
              (i_ext_funct3 == F3_MULH || i_ext_funct3 == F3_MULHSU);
      b_neg = i_ext_rs2[XLEN-1] && (i_ext_funct3 == F3_MULH);
    end
    a_mag = a_neg ? ('0 - i_ext_rs1) : i_ext_rs1;
    b_mag = b_neg ? ('0 - i_ext_rs2) : i_ext_rs2;
  end

  assign load   = (state_q == S_IDLE) && i_mdu_valid;
  assign is_div = load ? i_ext_funct3[2] : f3_q[2];

  serv_mdu_iter #(.UNROLL(UNROLL)) u_iter (
    .clk      (clk),
    .i_load   (load),
    .i_step   (state_q == S_BUSY),
    .i_is_div (is_div),
    .i_a      (a_mag),
    .i_b      (b_mag),
    .o_hi     (hi),
    .o_lo     (lo)
  );

  // Sign fixup. A zero divisor keeps the all-ones quotient unnegated, which
  // together with the plain algorithm also yields the overflow results.
  always_comb begin
    prod     = {hi, lo};
    prod_fix = (sa_q ^ sb_q) ? ('0 - prod) : prod;
    q_fix    = ((sa_q ^ sb_q) && !bz_q) ? ('0 - lo) : lo;
    r_fix    = sa_q ? ('0 - hi) : hi;
    if (f3_q[2])
      result = f3_q[1] ? r_fix : q_fix;
    else
      result = (f3_q == F3_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    bz_d    = bz_q;
    ready_d = 1'b0;
    rd_d    = '0;
    case (state_q)
      S_IDLE: begin
        if (i_mdu_valid) begin
          f3_d    = i_ext_funct3;
          sa_d    = a_neg;
          sb_d    = b_neg;
          bz_d    = (i_ext_rs2 == '0);
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LAST) state_d = S_DONE;
      end
      S_DONE: begin
        ready_d = 1'b1;
        rd_d    = result;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!i_mdu_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (i_rst && RST_OUTS) begin
      ready_q <= 1'b0;
      rd_q    <= '0;
    end else begin
      ready_q <= ready_d;
      rd_q    <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
    f3_q  <= f3_d;
    sa_q  <= sa_d;
    sb_q  <= sb_d;
    bz_q  <= bz_d;
  end

  assign o_ext_ready = ready_q;
  assign o_ext_rd    = rd_q;

endmodule

// File: tb/tb_serv_mdu_responder.sv
// Directed and randomised checks of serv_mdu_responder with UNROLL=1 and
// UNROLL=4 instances sharing one request stream.
module tb_serv_mdu_responder;
  import serv_mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [31:0] rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] rd1, rd4;
  logic        rdy1, rdy4;

  int n_assert = 0;
  int n_fail   = 0;

  int cyc, lat1, lat4, p1, p4, leak, h;
  logic [31:0] c1, c4;

  always #5 clk = ~clk;

  serv_mdu_responder #(.UNROLL(1), .RESET_STRATEGY("MINI")) u1 (
    .clk(clk), .i_rst(rst), .i_mdu_valid(valid), .i_ext_rs1(rs1),
    .i_ext_rs2(rs2), .i_ext_funct3(f3), .o_ext_rd(rd1), .o_ext_ready(rdy1)
  );

  serv_mdu_responder #(.UNROLL(4), .RESET_STRATEGY("MINI")) u4 (
    .clk(clk), .i_rst(rst), .i_mdu_valid(valid), .i_ext_rs1(rs1),
    .i_ext_rs2(rs2), .i_ext_funct3(f3), .o_ext_rd(rd4), .o_ext_ready(rdy4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] sa, sb, ub, p;
    logic [63:0] up;
    int ia, ib;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ub = {32'b0, b};
    ia = a;
    ib = b;
    case (op)
      F3_MUL:    begin p = sa * sb; return p[31:0]; end
      F3_MULH:   begin p = sa * sb; return p[63:32]; end
      F3_MULHSU: begin p = sa * ub; return p[63:32]; end
      F3_MULHU:  begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      F3_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      F3_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(ia % ib);
      end
      F3_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic sample();
    if (rdy1) begin
      p1++;
      if (lat1 < 0) begin lat1 = cyc - 1; c1 = rd1; end
    end else if (rd1 !== 32'h0) leak++;
    if (rdy4) begin
      p4++;
      if (lat4 < 0) begin lat4 = cyc - 1; c4 = rd4; end
    end else if (rd4 !== 32'h0) leak++;
  endtask

  // Issues one op, scrambles the inputs once the op is in flight, holds valid
  // `hold` cycles past the ready pulse, then leaves `gap` idle cycles.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp,
                        input int hold, input int gap);
    @(negedge clk);
    f3 = op; rs1 = a; rs2 = b; valid = 1'b1;
    cyc = 0; lat1 = -1; lat4 = -1; p1 = 0; p4 = 0; leak = 0; h = 0;
    c1 = 32'h0; c4 = 32'h0;
    while ((lat1 < 0 || h < hold) && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 2) begin rs1 = ~a; rs2 = b ^ 32'h5A5A_0001; f3 = ~op; end
      if (lat1 >= 0) h++;
      sample();
    end
    @(negedge clk);
    valid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      @(posedge clk); #1;
      cyc++;
      sample();
    end
    check($sformatf("%s rd_u1", tag), c1, exp);
    check($sformatf("%s rd_u4", tag), c4, exp);
    check($sformatf("%s lat_u1", tag), 32'(lat1), 32'd33);
    check($sformatf("%s lat_u4", tag), 32'(lat4), 32'd9);
    check($sformatf("%s pulses_u1", tag), 32'(p1), 32'd1);
    check($sformatf("%s pulses_u4", tag), 32'(p4), 32'd1);
    check($sformatf("%s rd_zero_outside", tag), 32'(leak), 32'd0);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    rst = 1'b1; valid = 1'b0; rs1 = '0; rs2 = '0; f3 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset ready_u1", 32'(rdy1), 32'd0);
    check("reset rd_u1", rd1, 32'h0);
    check("reset ready_u4", 32'(rdy4), 32'd0);
    check("reset rd_u4", rd4, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    run_op("MULHU max",    F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 1);
    run_op("MULH minmin",  F3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, 1);
    run_op("MUL minmin",   F3_MUL,    32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 0, 1);
    run_op("MULHSU -1*2",  F3_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 0, 1);
    run_op("MUL 3*-5",     F3_MUL,    32'h0000_0003, 32'hFFFF_FFFB, 32'hFFFF_FFF1, 0, 1);
    run_op("DIV -7/2",     F3_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 0, 1);
    run_op("REM -7/2",     F3_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 0, 1);
    run_op("DIVU 100/7",   F3_DIVU,   32'd100,       32'd7,         32'd14,        0, 1);
    run_op("REMU 100/7",   F3_REMU,   32'd100,       32'd7,         32'd2,         0, 1);
    run_op("DIV 5/0",      F3_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 0, 1);
    run_op("REM -5/0",     F3_REM,    32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 0, 1);
    run_op("DIV ovf",      F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1);
    run_op("REM ovf",      F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0, 1);
    run_op("DIVU hold3",   F3_DIVU,   32'd1000,      32'd3,         32'd333,       3, 2);

    // Reset during iteration: abandoned op must not produce a ready pulse.
    @(negedge clk);
    f3 = F3_DIVU; rs1 = 32'd1000; rs2 = 32'd3; valid = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; valid = 1'b0;
    @(posedge clk); #1;
    check("midreset ready_u1", 32'(rdy1), 32'd0);
    check("midreset rd_u1", rd1, 32'h0);
    check("midreset ready_u4", 32'(rdy4), 32'd0);
    check("midreset rd_u4", rd4, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    p1 = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (rdy1) p1++;
    end
    check("midreset no_ready", 32'(p1), 32'd0);
    run_op("after reset",  F3_REMU,   32'd1000,      32'd3,         32'd1,         0, 1);

    for (int n = 0; n < 150; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = pick();
      rb  = pick();
      run_op($sformatf("rand%0d f3=%0d a=%h b=%h", n, rop, ra, rb),
             rop, ra, rb, ref_mdu(rop, ra, rb), 0, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
